vga_rect_fill: RTL and testbench

- Drawing engine that feeds the video memory write port, directly upstream of the VGA scan-out controller.
- Accepts one rectangle command (origin, size, colour) and walks it row-major, emitting one pixel write per cycle.
- Each write carries x, y, the translated memory address and the colour.
- Used for screen clear, maze walls and sprite backgrounds. The scan-out side reads the same memory independently.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/vga_address_translator.sv | 17 +
 rtl/vga_rect_fill.sv | 198 +++++++++++++++++++
 tb/tb_vga_rect_fill.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: screen geometry, coordinate/address widths,
// pixel colour depth, the rectangle-fill state encoding and colour constants.
package vga_pkg;

  localparam int COLOR_DEPTH = 3;
  localparam int nX          = 8;
  localparam int nY          = 7;
  localparam int Mn          = 15;
  localparam int COLS        = 160;
  localparam int ROWS        = 120;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    FINISH = 2'd2
  } fill_state_e;

  localparam logic [COLOR_DEPTH-1:0] BLACK = '0;
  localparam logic [COLOR_DEPTH-1:0] WHITE = '1;

endpackage

// File: rtl/vga_address_translator.sv
// Maps a screen coordinate (x, y) to a linear video-memory address,
// row-major with COLS pixels per row. The scan-out side uses the same mapping.
module vga_address_translator #(
  parameter int nX   = 8,
  parameter int nY   = 7,
  parameter int Mn   = 15,
  parameter int COLS = 160
) (
  input  logic [nX-1:0] x,
  input  logic [nY-1:0] y,
  output logic [Mn-1:0] mem_address
);

  // address = y * COLS + x
  assign mem_address = Mn'(y) * Mn'(COLS) + Mn'(x);

endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle fill engine: accepts one (origin, size, colour) command, clips it
// to the visible screen and emits one video-memory pixel write per cycle,
// walking the rectangle row-major.
// Optional build macro VGA_RECT_FILL_STALL_EN adds a wr_ready input; the walk
// then advances only on cycles where the write is accepted (wr_en && wr_ready).
//
// Write handshake: a write is presented while wr_en=1; wr_x/wr_y/wr_color
// (and wr_address) are stable for as long as wr_en=1 and the write has not
// been accepted. Without the stall macro every presented write is accepted
// in the cycle it appears.
module vga_rect_fill #(
  parameter int COLOR_DEPTH = vga_pkg::COLOR_DEPTH,
  parameter int nX          = vga_pkg::nX,
  parameter int nY          = vga_pkg::nY,
  parameter int Mn          = vga_pkg::Mn,
  parameter int COLS        = vga_pkg::COLS,
  parameter int ROWS        = vga_pkg::ROWS
) (
  input  logic                   vga_clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [nX-1:0]          x0,
  input  logic [nY-1:0]          y0,
  input  logic [nX-1:0]          width,
  input  logic [nY-1:0]          height,
  input  logic [COLOR_DEPTH-1:0] color,
`ifdef VGA_RECT_FILL_STALL_EN
  input  logic                   wr_ready,
`endif
  output logic                   busy,
  output logic                   done,
  output logic                   wr_en,
  output logic [nX-1:0]          wr_x,
  output logic [nY-1:0]          wr_y,
  output logic [Mn-1:0]          wr_address,
  output logic [COLOR_DEPTH-1:0] wr_color
);

  import vga_pkg::*;

  fill_state_e            state_q, state_d;
  logic [nX-1:0]          x0_q, x0_d;
  logic [nY-1:0]          y0_q, y0_d;
  logic [nX:0]            ew_q, ew_d;
  logic [nY:0]            eh_q, eh_d;
  logic [nX-1:0]          cx_q, cx_d;
  logic [nY-1:0]          cy_q, cy_d;
  logic [COLOR_DEPTH-1:0] color_q, color_d;
  logic [nX-1:0]          wr_x_q, wr_x_d;
  logic [nY-1:0]          wr_y_q, wr_y_d;
  logic [COLOR_DEPTH-1:0] wr_color_q, wr_color_d;

  logic [nX:0] ew_in;
  logic [nY:0] eh_in;
  logic        advance;
  logic        row_end;
  logic        last_px;

`ifdef VGA_RECT_FILL_STALL_EN
  assign advance = wr_ready;
`else
  assign advance = 1'b1;
`endif

  // Clip the requested width to the visible columns (one extra bit, no wrap)
  always_comb begin
    ew_in = '0;
    if ({1'b0, x0} < (nX+1)'(COLS)) begin
      ew_in = (nX+1)'(COLS) - {1'b0, x0};
      if ({1'b0, width} < ew_in) ew_in = {1'b0, width};
    end
  end

  // Clip the requested height to the visible rows (one extra bit, no wrap)
  always_comb begin
    eh_in = '0;
    if ({1'b0, y0} < (nY+1)'(ROWS)) begin
      eh_in = (nY+1)'(ROWS) - {1'b0, y0};
      if ({1'b0, height} < eh_in) eh_in = {1'b0, height};
    end
  end

  assign row_end = ({1'b0, cx_q} == (ew_q - (nX+1)'(1)));
  assign last_px = row_end && ({1'b0, cy_q} == (eh_q - (nY+1)'(1)));

  // State register
  always_ff @(posedge vga_clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if ((ew_in == '0) || (eh_in == '0)) state_d = FINISH;
          else                                state_d = FILL;
        end
      end
      FILL: begin
        if (advance && last_px) state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the current state
  always_comb begin
    busy  = (state_q == FILL);
    wr_en = (state_q == FILL);
    done  = (state_q == FINISH);
  end

  // Command latch, walk counters and next write coordinates
  always_comb begin
    x0_d       = x0_q;
    y0_d       = y0_q;
    ew_d       = ew_q;
    eh_d       = eh_q;
    color_d    = color_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    wr_x_d     = wr_x_q;
    wr_y_d     = wr_y_q;
    wr_color_d = wr_color_q;
    if ((state_q == IDLE) && start) begin
      x0_d    = x0;
      y0_d    = y0;
      ew_d    = ew_in;
      eh_d    = eh_in;
      color_d = color;
      cx_d    = '0;
      cy_d    = '0;
      // Empty commands leave the write bus holding its previous values
      if (state_d == FILL) begin
        wr_x_d     = x0;
        wr_y_d     = y0;
        wr_color_d = color;
      end
    end else if ((state_q == FILL) && advance && !last_px) begin
      if (row_end) begin
        cx_d   = '0;
        cy_d   = cy_q + nY'(1);
        wr_x_d = x0_q;
        wr_y_d = wr_y_q + nY'(1);
      end else begin
        cx_d   = cx_q + nX'(1);
        wr_x_d = wr_x_q + nX'(1);
      end
    end
  end

  // Datapath registers
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      x0_q       <= '0;
      y0_q       <= '0;
      ew_q       <= '0;
      eh_q       <= '0;
      color_q    <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      wr_x_q     <= '0;
      wr_y_q     <= '0;
      wr_color_q <= '0;
    end else begin
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      ew_q       <= ew_d;
      eh_q       <= eh_d;
      color_q    <= color_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      wr_x_q     <= wr_x_d;
      wr_y_q     <= wr_y_d;
      wr_color_q <= wr_color_d;
    end
  end

  assign wr_x     = wr_x_q;
  assign wr_y     = wr_y_q;
  assign wr_color = wr_color_q;

  vga_address_translator #(
    .nX  (nX),
    .nY  (nY),
    .Mn  (Mn),
    .COLS(COLS)
  ) u_translator (
    .x          (wr_x_q),
    .y          (wr_y_q),
    .mem_address(wr_address)
  );

endmodule

// File: tb/tb_vga_rect_fill.sv
// Bench for vga_rect_fill: directed command sequence, write scoreboard,
// cycle-accurate done/busy checks, reset-mid-fill and (when built with
// VGA_RECT_FILL_STALL_EN) a write-stall sequence.
module tb_vga_rect_fill;

  localparam int SCOLS = 160;
  localparam int SROWS = 120;
  localparam int W     = 8 + 7 + 15 + 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  x0 = '0;
  logic [6:0]  y0 = '0;
  logic [7:0]  width = '0;
  logic [6:0]  height = '0;
  logic [2:0]  color = '0;
  logic        wr_ready = 1'b1;
  logic        busy, done, wr_en;
  logic [7:0]  wr_x;
  logic [6:0]  wr_y;
  logic [14:0] wr_address;
  logic [2:0]  wr_color;

  int tests_run = 0;
  int fails     = 0;
  int wr_cnt    = 0;
  logic [W-1:0] exp_q[$];

  vga_rect_fill dut (
    .vga_clock (clk),
    .reset     (rst),
    .start     (start),
    .x0        (x0),
    .y0        (y0),
    .width     (width),
    .height    (height),
    .color     (color),
`ifdef VGA_RECT_FILL_STALL_EN
    .wr_ready  (wr_ready),
`endif
    .busy      (busy),
    .done      (done),
    .wr_en     (wr_en),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_address(wr_address),
    .wr_color  (wr_color)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance to just after the next falling edge (inputs change here)
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int clip(input int o, input int s, input int lim);
    if (o >= lim) return 0;
    return (s < (lim - o)) ? s : (lim - o);
  endfunction

  task automatic push_rect(input int x, input int y, input int ew, input int eh, input int c);
    for (int r = 0; r < eh; r++) begin
      for (int q = 0; q < ew; q++) begin
        exp_q.push_back({8'(x + q), 7'(y + r), 15'((y + r) * SCOLS + (x + q)), 3'(c)});
      end
    end
  endtask

  // Scoreboard: every presented write must match the head of the queue;
  // the head is retired only when the write is accepted.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'({wr_x, wr_y, wr_color}), 64'hFFFF_FFFF);
      end else begin
        chk("write", 64'({wr_x, wr_y, wr_address, wr_color}), 64'(exp_q[0]));
        if (wr_ready) begin
          void'(exp_q.pop_front());
          wr_cnt++;
        end
      end
    end
  end

  // Issue one command; optionally pulse a conflicting start during cycle N+glitch
  task automatic run_cmd(input string tag, input int x, input int y, input int w,
                         input int h, input int c, input int glitch);
    int  ew, eh, n_px, done_k;
    bit  fill_bad;
    ew   = clip(x, w, SCOLS);
    eh   = clip(y, h, SROWS);
    n_px = ew * eh;
    exp_q.delete();
    wr_cnt = 0;
    push_rect(x, y, ew, eh, c);
    x0 = 8'(x); y0 = 7'(y); width = 8'(w); height = 7'(h); color = 3'(c);
    start = 1'b1;
    tick();
    start  = 1'b0;
    x0     = 8'($urandom);
    y0     = 7'($urandom);
    width  = 8'($urandom);
    height = 7'($urandom);
    color  = 3'($urandom);
    done_k   = -1;
    fill_bad = 1'b0;
    for (int k = 1; k <= n_px + 4; k++) begin
      if (k == glitch) begin
        start = 1'b1; x0 = 8'd0; y0 = 7'd0; width = 8'd3; height = 7'd3; color = 3'(~c);
      end
      if (done === 1'b1) begin
        done_k = k;
        break;
      end
      if (busy !== 1'b1 || wr_en !== 1'b1) fill_bad = 1'b1;
      tick();
      start = 1'b0;
    end
    chk({tag, "_done_cycle"}, 64'(done_k), 64'(n_px + 1));
    chk({tag, "_busy_at_done"}, 64'({busy, wr_en}), 64'(0));
    chk({tag, "_busy_during_fill"}, 64'(fill_bad), 64'(0));
    tick();
    start = 1'b0;
    chk({tag, "_idle_after"}, 64'({busy, wr_en, done}), 64'(0));
    chk({tag, "_write_count"}, 64'(wr_cnt), 64'(n_px));
    chk({tag, "_leftover"}, 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_ctrl", 64'({busy, done, wr_en}), 64'(0));
    chk("reset_bus", 64'({wr_x, wr_y, wr_color}), 64'(0));
    rst = 1'b0;
    tick();

    // Directed rectangles
    run_cmd("rect_5_3", 5, 3, 4, 2, 5, 3);
    run_cmd("finish_start", 5, 3, 4, 2, 2, 9);
    run_cmd("clip_corner", 158, 118, 10, 10, 6, 2);
    run_cmd("zero_w", 10, 10, 0, 5, 1, 0);
    run_cmd("zero_h", 10, 10, 5, 0, 1, 0);
    run_cmd("x_off", 200, 10, 5, 5, 1, 0);
    run_cmd("y_off", 10, 125, 5, 5, 1, 0);
    run_cmd("single", 159, 119, 1, 1, 7, 0);

    // Reset during a 10x10 fill at the 37th write
    begin
      int guard;
      exp_q.delete();
      wr_cnt = 0;
      push_rect(0, 0, 10, 10, 5);
      x0 = 8'd0; y0 = 7'd0; width = 8'd10; height = 7'd10; color = 3'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      guard = 0;
      while (wr_cnt < 37 && guard < 200) begin
        tick();
        guard++;
      end
      chk("rst_mid_reach37", 64'(wr_cnt), 64'(37));
      rst = 1'b1;
      tick();
      chk("rst_mid_ctrl", 64'({busy, done, wr_en}), 64'(0));
      chk("rst_mid_bus", 64'({wr_x, wr_y, wr_color}), 64'(0));
      rst = 1'b0;
      exp_q.delete();
      tick();
      chk("rst_mid_idle", 64'({busy, done, wr_en}), 64'(0));
    end
    run_cmd("after_reset", 2, 2, 3, 3, 7, 0);

    // Random small rectangles, some partly off-screen
    for (int i = 0; i < 6; i++) begin
      run_cmd("rand", int'($urandom_range(0, 170)), int'($urandom_range(0, 127)),
              int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
              int'($urandom_range(0, 7)), int'($urandom_range(1, 4)));
    end

    // Full screen clear
    run_cmd("clear", 0, 0, 160, 120, 0, 0);

`ifdef VGA_RECT_FILL_STALL_EN
    // 2x1 fill with wr_ready 1,0,0,1 over the first four write cycles
    begin
      logic [3:0] pat;
      int         xs[4];
      pat = 4'b1001;
      xs[0] = 10; xs[1] = 11; xs[2] = 11; xs[3] = 11;
      exp_q.delete();
      wr_cnt = 0;
      push_rect(10, 20, 2, 1, 6);
      x0 = 8'd10; y0 = 7'd20; width = 8'd2; height = 7'd1; color = 3'd6;
      start = 1'b1;
      wr_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk);
        #1;
        start    = 1'b0;
        wr_ready = pat[3 - i];
        @(negedge clk);
        #1;
        chk("stall_wr_en", 64'({busy, wr_en}), 64'(3));
        chk("stall_wr_x", 64'(wr_x), 64'(xs[i]));
      end
      @(posedge clk);
      #1;
      wr_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("stall_done", 64'({done, wr_en, busy}), 64'(4));
      chk("stall_count", 64'(wr_cnt), 64'(2));
      chk("stall_leftover", 64'(exp_q.size()), 64'(0));
      tick();
      chk("stall_idle", 64'({busy, wr_en, done}), 64'(0));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
